// File: rtl/dec_token_parser_if.sv
// Byte-in / token-out handshake bundle for dec_token_parser.
// master drives bytes and consumes tokens; slave is the parser itself.
interface dec_token_parser_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic [7:0]       out_tag;
    logic             out_overflow;
    logic             out_last;
    logic [15:0]      token_count;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_value,
        input  out_tag,
        input  out_overflow,
        input  out_last,
        input  token_count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_value,
        output out_tag,
        output out_overflow,
        output out_last,
        output token_count
    );
endinterface

// File: rtl/dec_token_parser.sv
// Streaming decimal tokeniser: accumulates digits, captures a one-letter prefix tag
// and emits {tag, value, overflow, last} when a delimiter closes the token.
module dec_token_parser #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          ASCII_IN  = 1'b1,
    parameter logic [7:0]  LAST_CHAR = 8'd10
) (
    input logic               clk,
    input logic               rst,
    dec_token_parser_if.slave bus
);
    localparam int unsigned XW = WIDTH + 4;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [7:0]       tag;
    logic             ovf;

    logic             accept;
    logic             is_digit;
    logic             is_letter;
    logic [3:0]       digit;
    logic [XW-1:0]    mac;

    // A new byte is taken whenever the output slot is free or being drained this edge.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Byte classification; letters only exist in ASCII mode.
    always_comb begin
        is_digit  = 1'b0;
        is_letter = 1'b0;
        digit     = 4'd0;
        if (ASCII_IN) begin
            is_digit  = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
            is_letter = ((bus.in_data >= 8'h41) && (bus.in_data <= 8'h5A)) ||
                        ((bus.in_data >= 8'h61) && (bus.in_data <= 8'h7A));
            digit     = 4'(bus.in_data - 8'h30);
        end else begin
            is_digit  = bus.in_data < 8'd10;
            digit     = bus.in_data[3:0];
        end
    end

    // Four spare bits hold acc*10+9 exactly, so any set upper bit marks overflow.
    assign mac = XW'(acc) * XW'(10) + XW'(digit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            acc              <= '0;
            tag              <= 8'h00;
            ovf              <= 1'b0;
            bus.out_valid    <= 1'b0;
            bus.out_value    <= '0;
            bus.out_tag      <= 8'h00;
            bus.out_overflow <= 1'b0;
            bus.out_last     <= 1'b0;
            bus.token_count  <= 16'd0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (is_digit) begin
                            acc   <= WIDTH'(digit);
                            ovf   <= 1'b0;
                            state <= ACCUM;
                        end else if (is_letter) begin
                            tag <= bus.in_data;
                        end else begin
                            tag <= 8'h00;
                        end
                    end
                    ACCUM: begin
                        if (is_digit) begin
                            acc <= mac[WIDTH-1:0];
                            ovf <= ovf | (|mac[XW-1:WIDTH]);
                        end else begin
                            // Close the token; a letter also starts the next tag.
                            bus.out_valid    <= 1'b1;
                            bus.out_value    <= acc;
                            bus.out_tag      <= tag;
                            bus.out_overflow <= ovf;
                            bus.out_last     <= (bus.in_data == LAST_CHAR);
                            bus.token_count  <= bus.token_count + 16'd1;
                            acc              <= '0;
                            ovf              <= 1'b0;
                            tag              <= is_letter ? bus.in_data : 8'h00;
                            state            <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dec_token_parser.sv
// Directed scoreboard bench for dec_token_parser: three instances cover WIDTH=32 ASCII,
// WIDTH=8 ASCII and WIDTH=32 raw-digit modes.
module tb_dec_token_parser;
    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] value;
        logic        ovf;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    exp_t q32[$];
    exp_t q8[$];
    exp_t qr[$];

    always #5 clk = ~clk;

    dec_token_parser_if #(.WIDTH(32)) if32();
    dec_token_parser_if #(.WIDTH(8))  if8();
    dec_token_parser_if #(.WIDTH(32)) ifr();

    dec_token_parser #(.WIDTH(32), .ASCII_IN(1'b1), .LAST_CHAR(8'd10)) u32 (
        .clk(clk), .rst(rst), .bus(if32.slave));
    dec_token_parser #(.WIDTH(8), .ASCII_IN(1'b1), .LAST_CHAR(8'd10)) u8 (
        .clk(clk), .rst(rst), .bus(if8.slave));
    dec_token_parser #(.WIDTH(32), .ASCII_IN(1'b0), .LAST_CHAR(8'd10)) ur (
        .clk(clk), .rst(rst), .bus(ifr.slave));

    function automatic exp_t mk(input logic [7:0] t, input logic [31:0] v,
                                input logic o, input logic l);
        exp_t e;
        e.tag = t; e.value = v; e.ovf = o; e.last = l;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge, well clear of both edges.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input int d, input logic v, input logic [7:0] b);
        case (d)
            0:       begin if32.in_valid = v; if32.in_data = b; end
            1:       begin if8.in_valid  = v; if8.in_data  = b; end
            default: begin ifr.in_valid  = v; ifr.in_data  = b; end
        endcase
    endtask

    function automatic logic rdy(input int d);
        case (d)
            0:       return if32.in_ready;
            1:       return if8.in_ready;
            default: return ifr.in_ready;
        endcase
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0:       return q32.size();
            1:       return q8.size();
            default: return qr.size();
        endcase
    endfunction

    task automatic send(input int d, input logic [7:0] b);
        int n = 0;
        set_in(d, 1'b1, b);
        while (!rdy(d) && n < 200) begin
            step();
            n++;
        end
        chk("in_ready_timeout", 64'(n < 200), 64'd1);
        step();
        set_in(d, 1'b0, 8'h00);
    endtask

    task automatic send_str(input int d, input string s);
        for (int i = 0; i < s.len(); i++) send(d, s[i]);
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (qsize(d) != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_pending", 64'(qsize(d)), 64'd0);
        step();
    endtask

    // Scoreboard monitors: a token is consumed on the edge after out_valid && out_ready.
    exp_t held32;
    logic stall32 = 1'b0;
    always @(negedge clk) begin
        exp_t got, e;
        if (if32.out_valid) begin
            got = mk(if32.out_tag, if32.out_value, if32.out_overflow, if32.out_last);
            if (stall32) chk("hold32", 64'(got), 64'(held32));
            if (if32.out_ready && !rst) begin
                chk("extra_token32", 64'(q32.size() > 0), 64'd1);
                if (q32.size() > 0) begin
                    e = q32.pop_front();
                    chk("tok32", 64'(got), 64'(e));
                end
                stall32 = 1'b0;
            end else begin
                stall32 = 1'b1;
                held32  = got;
            end
        end else begin
            stall32 = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t got, e;
        if (if8.out_valid && if8.out_ready && !rst) begin
            got = mk(if8.out_tag, {24'h0, if8.out_value}, if8.out_overflow, if8.out_last);
            chk("extra_token8", 64'(q8.size() > 0), 64'd1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("tok8", 64'(got), 64'(e));
            end
        end
    end

    always @(negedge clk) begin
        exp_t got, e;
        if (ifr.out_valid && ifr.out_ready && !rst) begin
            got = mk(ifr.out_tag, ifr.out_value, ifr.out_overflow, ifr.out_last);
            chk("extra_tokenr", 64'(qr.size() > 0), 64'd1);
            if (qr.size() > 0) begin
                e = qr.pop_front();
                chk("tokr", 64'(got), 64'(e));
            end
        end
    end

    initial begin
        if32.in_valid = 1'b0; if32.in_data = 8'h00; if32.out_ready = 1'b0;
        if8.in_valid  = 1'b0; if8.in_data  = 8'h00; if8.out_ready  = 1'b1;
        ifr.in_valid  = 1'b0; ifr.in_data  = 8'h00; ifr.out_ready  = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 64'(if32.out_valid), 64'd0);
        chk("rst_in_ready", 64'(if32.in_ready), 64'd1);
        chk("rst_token_count", 64'(if32.token_count), 64'd0);
        chk("rst_out_value", 64'(if32.out_value), 64'd0);
        chk("rst_out_tag", 64'(if32.out_tag), 64'd0);

        // Tagged tokens, last-char marking
        if32.out_ready = 1'b1;
        q32.push_back(mk(8'h52, 32'd75, 1'b0, 1'b0));
        q32.push_back(mk(8'h44, 32'd30, 1'b0, 1'b1));
        send_str(0, "R75,D30\n");
        drain(0);
        chk("count_t1", 64'(if32.token_count), 64'd2);

        // Empty delimiters emit nothing
        q32.push_back(mk(8'h00, 32'd5, 1'b0, 1'b0));
        send_str(0, ",,\n5,");
        drain(0);
        chk("count_t3", 64'(if32.token_count), 64'd3);

        // Multi-letter prefix, leading zeros, letter closing a token
        q32.push_back(mk(8'h42, 32'd7, 1'b0, 1'b0));
        q32.push_back(mk(8'h58, 32'd5, 1'b0, 1'b0));
        q32.push_back(mk(8'h59, 32'd6, 1'b0, 1'b0));
        send_str(0, "AB007,X5Y6,");
        drain(0);
        chk("count_prefix", 64'(if32.token_count), 64'd6);

        // Backpressure
        if32.out_ready = 1'b0;
        q32.push_back(mk(8'h55, 32'd1, 1'b0, 1'b0));
        q32.push_back(mk(8'h4C, 32'd2, 1'b0, 1'b0));
        send_str(0, "U1,");
        chk("bp_out_valid", 64'(if32.out_valid), 64'd1);
        chk("bp_in_ready_low", 64'(if32.in_ready), 64'd0);
        set_in(0, 1'b1, 8'h4C);
        for (int i = 0; i < 3; i++) step();
        chk("bp_in_ready_held", 64'(if32.in_ready), 64'd0);
        chk("bp_tag_held", 64'(if32.out_tag), 64'h55);
        if32.out_ready = 1'b1;
        send_str(0, "L2,");
        drain(0);
        chk("count_bp", 64'(if32.token_count), 64'd8);

        // Reset discards a pending token
        if32.out_ready = 1'b0;
        send_str(0, "9,");
        chk("pend_out_valid", 64'(if32.out_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_pend_valid", 64'(if32.out_valid), 64'd0);
        chk("rst_pend_count", 64'(if32.token_count), 64'd0);
        chk("rst_pend_ready", 64'(if32.in_ready), 64'd1);

        // Reset mid-token
        if32.out_ready = 1'b1;
        send_str(0, "R12");
        rst = 1'b1;
        step();
        rst = 1'b0;
        q32.push_back(mk(8'h00, 32'd3, 1'b0, 1'b0));
        send_str(0, "3,");
        drain(0);
        chk("count_t5", 64'(if32.token_count), 64'd1);

        // WIDTH=8 wrap and overflow, overflow clears per token
        q8.push_back(mk(8'h00, 32'd44, 1'b1, 1'b0));
        q8.push_back(mk(8'h00, 32'd255, 1'b0, 1'b0));
        q8.push_back(mk(8'h00, 32'd0, 1'b0, 1'b1));
        send_str(1, "300,255,0\n");
        drain(1);
        chk("count_w8", 64'(if8.token_count), 64'd3);

        // Raw-digit mode: 0x0A is last, 0x0B and ASCII letters are plain delimiters
        qr.push_back(mk(8'h00, 32'd75, 1'b0, 1'b1));
        qr.push_back(mk(8'h00, 32'd12, 1'b0, 1'b0));
        qr.push_back(mk(8'h00, 32'd3, 1'b0, 1'b0));
        send(2, 8'h07); send(2, 8'h05); send(2, 8'h0A);
        send(2, 8'h01); send(2, 8'h02); send(2, 8'h0B);
        send(2, 8'h03); send(2, 8'h41);
        drain(2);
        chk("count_raw", 64'(ifr.token_count), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
